// File: rtl/census_cost_wta.sv
// Winner-take-all over a packed census/Hamming cost vector: scans LANES costs per
// cycle and reports the best disparity, its cost, the runner-up cost and a uniqueness flag.
module census_cost_wta #(
    parameter int NUM_DISP = 256,
    parameter int COST_W   = 4,
    parameter int LANES    = 16,
    parameter int DISP_W   = 8,
    parameter int UNIQ_TH  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DISP*COST_W-1:0] cost_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DISP_W-1:0]          out_disp,
    output logic [COST_W-1:0]          out_cost,
    output logic [COST_W-1:0]          out_cost2,
    output logic                       out_unique
);

    localparam int NUM_CHUNKS = NUM_DISP / LANES;
    localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                     state_q, state_d;
    logic                       started_q;
    logic [CHUNK_W-1:0]         chunk_q;
    logic [NUM_DISP*COST_W-1:0] cost_q;
    logic [COST_W-1:0]          min1_q, min2_q;
    logic [DISP_W-1:0]          best_q;

    logic                       accept;
    logic                       last_chunk;
    logic [COST_W-1:0]          c_min1, c_min2;
    logic [LANE_W-1:0]          c_idx;
    logic [COST_W-1:0]          m1_n, m2_n;
    logic [DISP_W-1:0]          best_n;
    logic [COST_W:0]            gap_n;
    logic                       uniq_n;

    assign accept     = en && in_valid && in_ready;
    assign last_chunk = (chunk_q == CHUNK_W'(NUM_CHUNKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)             state_d = SCAN;
            SCAN:    if (en && last_chunk)   state_d = DONE;
            DONE:    if (en && out_ready)    state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // in_ready stays low through reset and until the first clock edge afterwards.
    always_comb begin
        in_ready  = started_q && (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // NOTE: combinational scratch uses blocking '=' so each lane sees the previous lane's result;
    // all clocked state below uses non-blocking '<='.
    always_comb begin : chunk_scan
        logic [COST_W-1:0] lane;
        lane   = '0;
        c_min1 = '1;
        c_min2 = '1;
        c_idx  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = cost_q[(int'(chunk_q) * LANES + i) * COST_W +: COST_W];
            if (lane < c_min1) begin
                c_min2 = c_min1;
                c_min1 = lane;
                c_idx  = LANE_W'(i);
            end else if (lane < c_min2) begin
                c_min2 = lane;
            end
        end
    end

    // Strict '<' keeps the earlier (lower) disparity on ties; runner-up is the
    // second smallest of {min1, min2, chunk min, chunk second}.
    always_comb begin
        m1_n   = min1_q;
        m2_n   = min2_q;
        best_n = best_q;
        if (c_min1 < min1_q) begin
            m1_n   = c_min1;
            best_n = DISP_W'(int'(chunk_q) * LANES + int'(c_idx));
            m2_n   = (min1_q < c_min2) ? min1_q : c_min2;
        end else begin
            m2_n   = (c_min1 < min2_q) ? c_min1 : min2_q;
        end
        gap_n  = {1'b0, m2_n} - {1'b0, m1_n};
        uniq_n = (gap_n >= (COST_W + 1)'(UNIQ_TH));
    end

    // NOTE: the wide cost register has no reset; it is only read after a handshake loads it.
    always_ff @(posedge clk) begin
        if (accept) cost_q <= cost_vec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_q  <= 1'b0;
            chunk_q    <= '0;
            min1_q     <= '1;
            min2_q     <= '1;
            best_q     <= '0;
            out_disp   <= '0;
            out_cost   <= '0;
            out_cost2  <= '0;
            out_unique <= 1'b0;
        end else if (en) begin
            started_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        min1_q  <= '1;
                        min2_q  <= '1;
                        best_q  <= '0;
                        chunk_q <= '0;
                    end
                end
                SCAN: begin
                    min1_q  <= m1_n;
                    min2_q  <= m2_n;
                    best_q  <= best_n;
                    chunk_q <= chunk_q + CHUNK_W'(1);
                    if (last_chunk) begin
                        out_disp   <= best_n;
                        out_cost   <= m1_n;
                        out_cost2  <= m2_n;
                        out_unique <= uniq_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_census_cost_wta.sv
// Self-checking bench for census_cost_wta: directed corner cases plus randomized
// traffic compared every cycle against a behavioural WTA model.
module tb_census_cost_wta;

    localparam int ND = 256;
    localparam int CW = 4;
    localparam int VW = ND * CW;
    localparam int UNIQ_TH = 1;
    localparam int SCAN_CYCLES = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] cost_vec;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_disp;
    logic [3:0]    out_cost;
    logic [3:0]    out_cost2;
    logic          out_unique;

    int errors = 0;
    int checks = 0;
    int n_results = 0;

    typedef struct packed {
        logic [7:0] disp;
        logic [3:0] cost;
        logic [3:0] cost2;
        logic       uniq;
    } result_t;

    census_cost_wta dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .cost_vec(cost_vec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_disp(out_disp), .out_cost(out_cost), .out_cost2(out_cost2),
        .out_unique(out_unique)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: lowest cost at lowest disparity, then the minimum over every other disparity.
    function automatic result_t wta(input logic [VW-1:0] v);
        result_t r;
        int best = 0;
        int m1 = int'(v[3:0]);
        int m2 = 15;
        for (int d = 1; d < ND; d++)
            if (int'(v[d*CW +: CW]) < m1) begin m1 = int'(v[d*CW +: CW]); best = d; end
        for (int d = 0; d < ND; d++)
            if (d != best && int'(v[d*CW +: CW]) < m2) m2 = int'(v[d*CW +: CW]);
        r.disp  = 8'(best);
        r.cost  = 4'(m1);
        r.cost2 = 4'(m2);
        r.uniq  = ((m2 - m1) >= UNIQ_TH);
        return r;
    endfunction

    // Cycle-level model: an accepted vector is busy for SCAN_CYCLES enabled edges,
    // then held as a result until taken.
    int      m_phase = 0;   // 0 idle, 1 scanning, 2 result pending
    bit      m_started = 0;
    int      m_left = 0;
    result_t m_pend = '0;
    result_t m_out = '0;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_in_ready", in_ready, 0);
            check("reset_out_valid", out_valid, 0);
            check("reset_outputs", {out_disp, out_cost, out_cost2, out_unique}, 0);
            m_phase = 0; m_started = 0; m_left = 0; m_out = '0;
        end else begin
            check("in_ready", in_ready, m_started && m_phase == 0);
            check("out_valid", out_valid, m_phase == 2);
            check("out_disp", out_disp, m_out.disp);
            check("out_cost", out_cost, m_out.cost);
            check("out_cost2", out_cost2, m_out.cost2);
            check("out_unique", out_unique, m_out.uniq);
            if (en) begin
                if (m_phase == 0 && m_started && in_valid) begin
                    m_pend  = wta(cost_vec);
                    m_phase = 1;
                    m_left  = SCAN_CYCLES;
                end else if (m_phase == 1) begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 2; m_out = m_pend; end
                end else if (m_phase == 2 && out_ready) begin
                    m_phase = 0;
                    n_results++;
                end
                m_started = 1;
            end
        end
    end

    logic [VW-1:0] vec;

    task automatic fill(input int val);
        for (int d = 0; d < ND; d++) vec[d*CW +: CW] = 4'(val);
    endtask

    task automatic put(input int d, input int val);
        vec[d*CW +: CW] = 4'(val);
    endtask

    task automatic send();
        bit ok = 0;
        cost_vec = vec;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready && en) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                ok = 1;
            end
        end
        if (!ok) begin check("send_timeout", 0, 1); in_valid = 1'b0; end
    endtask

    task automatic wait_result(input int drop_at, output int lat, output result_t r);
        lat = 0;
        r = '0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == drop_at) en = 1'b0;
            if (drop_at > 0 && lat == drop_at + 3) en = 1'b1;
            if (out_valid) begin
                r = {out_disp, out_cost, out_cost2, out_unique};
                return;
            end
        end
        check("result_timeout", 0, 1);
    endtask

    task automatic expect_res(input string tag, input result_t r, input int d, input int c,
                              input int c2, input int u);
        check({tag, "_disp"}, r.disp, d);
        check({tag, "_cost"}, r.cost, c);
        check({tag, "_cost2"}, r.cost2, c2);
        check({tag, "_unique"}, r.uniq, u);
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        int lo = $urandom_range(0, 15);
        int mode = $urandom_range(0, 3);
        for (int d = 0; d < ND; d++) v[d*CW +: CW] = 4'($urandom_range(lo, 15));
        if (mode == 0) v[(ND-1)*CW +: CW] = 4'($urandom_range(0, lo));
        if (mode == 1) v[$urandom_range(0, ND-1)*CW +: CW] = 4'(lo);
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int      lat;
        result_t r;

        rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cost_vec = '0; vec = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("pre_edge_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("idle_outputs", {out_disp, out_cost, out_cost2, out_unique}, 0);

        fill(9); put(173, 2);
        send(); wait_result(0, lat, r);
        check("latency", lat, 16);
        expect_res("single", r, 173, 2, 9, 1);

        fill(15); put(20, 1); put(200, 1);
        send(); wait_result(0, lat, r);
        expect_res("tie", r, 20, 1, 1, 0);

        fill(7);
        send(); wait_result(0, lat, r);
        expect_res("all_equal", r, 0, 7, 7, 0);

        fill(12); put(255, 0); put(0, 1);
        send(); wait_result(0, lat, r);
        expect_res("edge", r, 255, 0, 1, 1);

        // en low while idle: the handshake must not be taken.
        @(posedge clk); #1;
        en = 1'b0; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 en = 1'b1; in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("en_low_no_accept", out_valid, 0);

        // Stall, enable gap, and a second vector offered while busy.
        out_ready = 1'b0;
        fill(10); put(100, 3); put(101, 4);
        send();
        fill(5); put(250, 4);
        cost_vec = vec; in_valid = 1'b1;
        wait_result(5, lat, r);
        check("latency_en_gap", lat, 19);
        expect_res("stall", r, 100, 3, 4, 1);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_hold", {out_disp, out_cost, out_cost2, out_unique}, r);
        end
        out_ready = 1'b1;
        send(); wait_result(0, lat, r);
        expect_res("second", r, 250, 4, 5, 1);

        // Reset while chunk 8 is pending.
        fill(6); put(30, 1);
        send();
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("abort_valid", out_valid, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", in_ready, 1);
        repeat (20) @(posedge clk);
        #1 check("abort_no_result", out_valid, 0);
        fill(3); put(64, 0);
        send(); wait_result(0, lat, r);
        expect_res("after_abort", r, 64, 0, 3, 1);

        // Randomized traffic; the per-cycle model does the checking.
        n_results = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            cost_vec  = rand_vec();
        end
        @(posedge clk); #1;
        in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1 check("random_results_seen", n_results >= 20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/census_cost_wta.md
Name: census_cost_wta

Overview:
- Consumes the packed 256-disparity Hamming cost vector produced by the census/Hamming stage. Each cost is 4 bits; disparity d occupies bits [d*4+3 : d*4].
- Performs a sequential winner-take-all scan and returns, per pixel:
  - the disparity with the lowest cost, its cost, and the second-lowest cost;
  - a uniqueness flag.
- Sits between the census_hamming cost generator and the disparity-map writer. It uses a valid/ready handshake on both sides.

Parameters:
- NUM_DISP, 256, number of disparities in the cost vector.
- COST_W, 4, width of one Hamming cost.
- LANES, 16, costs examined per scan cycle. NUM_DISP/LANES must be an integer.
- DISP_W, 8, disparity index width (log2 NUM_DISP).
- UNIQ_TH, 1, minimum (second-lowest cost - lowest cost) for out_unique=1.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Asynchronous, active-low reset.
- en  input  1  Global enable. When low, all state and outputs hold.
- in_valid  input  1  cost_vec is valid.
- in_ready  output  1  Block can accept cost_vec.
- cost_vec  input  NUM_DISP*COST_W  Packed Hamming costs, disparity 0 in the LSBs.
- out_valid  output  1  Result valid.
- out_ready  input  1  Downstream accepts the result.
- out_disp  output  DISP_W  Winning disparity.
- out_cost  output  COST_W  Minimum cost.
- out_cost2  output  COST_W  Minimum cost over all disparities except out_disp.
- out_unique  output  1  1 when (out_cost2 - out_cost) >= UNIQ_TH.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, chunk counter=0;
  - in_ready=0 while in reset, 1 from the first clock edge after deassertion;
  - out_valid=0, out_disp=0, out_cost=0, out_cost2=0, out_unique=0;
  - internal min1/min2 registers = all ones.
- en=0: no state, counter, register or output changes. A handshake is not taken while en=0, even if valid and ready are both high.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready & en: register cost_vec, set min1=min2={COST_W{1}}, best=0, counter=0, go to SCAN.
- SCAN (in_ready=0):
  - Each enabled cycle examines chunk k = disparities k*LANES .. k*LANES+LANES-1 of the registered vector.
  - Within the chunk, compute the lowest cost with its lowest index, and the chunk second-lowest.
  - Merge into running min1/best/min2. The running minimum is replaced only if the chunk minimum < min1 (strict), so ties resolve to the lowest disparity.
  - min2 is always the true second-smallest of the multiset seen so far. Equal values count, so all-equal costs give min2 = min1.
  - After chunk NUM_DISP/LANES-1, load the outputs, set out_valid=1, go to DONE.
- Latency: with en held high, out_valid rises on the 16th rising edge after the accepting edge (default parameters).
- DONE:
  - out_valid=1; outputs are stable and must not change while out_valid=1 and out_ready=0.
  - On out_ready & en: out_valid=0 on that edge, go to IDLE.
  - Output fields retain their last values until the next result.
- Throughput: one result per 18 cycles with out_ready tied high.
- Arithmetic:
  - out_cost2 - out_cost is computed unsigned and is never negative by construction.
  - out_unique uses a COST_W+1-bit comparison.
- Boundaries:
  - All costs equal → out_disp=0, out_cost=out_cost2, out_unique=0 (with UNIQ_TH≥1).
  - A minimum only at disparity NUM_DISP-1 must be reported.
  - in_valid during SCAN/DONE is ignored, and the vector is not consumed.
  - rst asserted mid-SCAN or mid-DONE aborts the pixel; no out_valid is produced for it.

Test Plan:
- Reset/idle: rst low then high, no input → in_ready=1 after the first edge, out_valid=0, all outputs 0.
- Single minimum: all costs 9 except d=173 cost 2 → out_disp=173, out_cost=2, out_cost2=9, out_unique=1, out_valid on the 16th edge after accept.
- Tie: d=20 and d=200 both cost 1, others 15 → out_disp=20, out_cost=1, out_cost2=1, out_unique=0. Also all costs 7 → out_disp=0, out_unique=0.
- Edge disparity: d=255 cost 0, d=0 cost 1, others 12 → out_disp=255, out_cost=0, out_cost2=1, out_unique=1.
- Backpressure/enable: hold out_ready=0 for 10 cycles, and toggle en low for 3 cycles mid-SCAN → outputs stable under stall, latency extended by exactly 3 cycles, a second in_valid is ignored until IDLE.
- Reset mid-scan: assert rst at SCAN chunk 8 → out_valid stays 0, in_ready=1 after release, the next vector is processed correctly.
